// File: rtl/rf_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu_pkg
// Description : Shared widths, ALU opcode encodings and instruction-field
//               positions for the register-file + ALU datapath slice.
// Revision    : 1.0  initial release
// ============================================================================
package rf_alu_pkg;

  localparam int DW    = 16;       // datapath width
  localparam int AW    = 3;        // register address width
  localparam int NREG  = 1 << AW;  // number of registers
  localparam int INS_W = 11;       // instruction field width seen by this slice

  // ALUop encodings
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Instruction field positions
  localparam int RD_LSB   = 8;   // Ins[10:8] destination / port-B alternate
  localparam int RM_LSB   = 5;   // Ins[7:5]  port-A address
  localparam int RN_LSB   = 2;   // Ins[4:2]  port-B address
  localparam int IMM8_W   = 8;   // Ins[7:0]  load-immediate byte
  localparam int IMM5_W   = 5;   // Ins[4:0]  short ALU immediate

  // Field extraction helpers
  function automatic logic [AW-1:0] ins_rd(input logic [INS_W-1:0] ins);
    return ins[RD_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] ins_rm(input logic [INS_W-1:0] ins);
    return ins[RM_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] ins_rn(input logic [INS_W-1:0] ins);
    return ins[RN_LSB +: AW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf8x16.sv
`default_nettype none
// ============================================================================
// Module      : rf8x16
// Description : 8 x 16 register file, async active-low reset, one synchronous
//               write port and two combinational read ports (no bypass).
// Revision    : 1.0  initial release
// ============================================================================
module rf8x16
  import rf_alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] regs_q [NREG];

  // Storage: clear on reset, write the addressed entry when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns old data
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/rf_plus_alu.sv
`default_nettype none
// ============================================================================
// Module      : rf_plus_alu
// Description : ID-stage register file, ID/EXE pipeline register and EXE-stage
//               add/sub ALU with flags, load-immediate formatter and OutR.
// Revision    : 1.0  initial release
// ============================================================================
module rf_plus_alu
  import rf_alu_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic [INS_W-1:0] Ins,
  input  logic [DW-1:0]    WBData,
  input  logic [DW-1:0]    MEMData,
  input  logic             WBRF,
  input  logic             WBresource,
  input  logic             RBresource,
  input  logic             OprandB,
  input  logic             LI,
  input  logic             Buff_OutR,
  input  logic             PSW_C,
  input  logic             ALUop,
  input  logic             Flag,
  output logic [DW-1:0]    Rm,
  output logic [DW-1:0]    Rd,
  output logic [DW-1:0]    OutR,
  output logic [DW-1:0]    OutR_EXE,
  output logic [DW-1:0]    LI_EXE,
  output logic [DW-1:0]    Sum,
  output logic             C,
  output logic             Z,
  output logic             N
);

  // ---------------------------------------------------------------- ID stage
  logic [DW-1:0] w_wr_data;
  logic [AW-1:0] w_rb_addr;

  assign w_wr_data = WBresource ? MEMData : WBData;
  assign w_rb_addr = RBresource ? ins_rd(Ins) : ins_rn(Ins);

  rf8x16 u_rf (
    .clk       (clk),
    .rst_n     (Reset),
    .we_i      (WBRF),
    .waddr_i   (ins_rd(Ins)),
    .wdata_i   (w_wr_data),
    .raddr_a_i (ins_rm(Ins)),
    .raddr_b_i (w_rb_addr),
    .rdata_a_o (Rm),
    .rdata_b_o (Rd)
  );

  // ------------------------------------------------------- ID/EXE register
  logic [DW-1:0]     a_exe_q, a_exe_d;
  logic [DW-1:0]     b_exe_q, b_exe_d;
  logic [DW-1:0]     d_exe_q, d_exe_d;
  logic [IMM8_W-1:0] imm_exe_q, imm_exe_d;

  assign a_exe_d   = Rm;
  assign b_exe_d   = OprandB ? {{(DW-IMM5_W){1'b0}}, Ins[IMM5_W-1:0]} : Rd;
  assign d_exe_d   = Rd;
  assign imm_exe_d = Ins[IMM8_W-1:0];

  // Pipeline register loads every cycle; there is no stall in this slice
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      a_exe_q   <= '0;
      b_exe_q   <= '0;
      d_exe_q   <= '0;
      imm_exe_q <= '0;
    end else begin
      a_exe_q   <= a_exe_d;
      b_exe_q   <= b_exe_d;
      d_exe_q   <= d_exe_d;
      imm_exe_q <= imm_exe_d;
    end
  end

  // --------------------------------------------------------------- EXE stage
  // Subtract is A + ~B + cin; cin is 1 for plain SUB, PSW_C for SBC, and for
  // add it is PSW_C only under ADC.
  logic          w_is_sub;
  logic          w_cin;
  logic [DW-1:0] w_b_op;
  logic [DW:0]   w_sum17;

  assign w_is_sub = (ALUop == ALU_SUB);
  assign w_cin    = Flag ? PSW_C : w_is_sub;
  assign w_b_op   = w_is_sub ? ~b_exe_q : b_exe_q;
  assign w_sum17  = {1'b0, a_exe_q} + {1'b0, w_b_op} + {{DW{1'b0}}, w_cin};

  assign Sum = w_sum17[DW-1:0];
  assign C   = w_sum17[DW];
  assign Z   = (Sum == '0);
  assign N   = Sum[DW-1];

  // LHI keeps the low byte of the destination, LLI zero-extends
  assign LI_EXE = LI ? {imm_exe_q, d_exe_q[IMM8_W-1:0]}
                     : {{(DW-IMM8_W){1'b0}}, imm_exe_q};

  logic [DW-1:0] outr_q, outr_d;

  assign outr_d   = Buff_OutR ? Sum : outr_q;
  assign OutR     = outr_q;
  assign OutR_EXE = outr_d;

  // Result buffer captures the ALU result only when asked, otherwise holds
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      outr_q <= '0;
    end else begin
      outr_q <= outr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_plus_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_plus_alu
// Description : Self-checking bench: directed vector table, hand sequences for
//               reset, and random stimulus against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        Reset;
  logic [10:0] Ins;
  logic [15:0] WBData, MEMData;
  logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR;
  logic        PSW_C, ALUop, Flag;
  logic [15:0] Rm, Rd, OutR, OutR_EXE, LI_EXE, Sum;
  logic        C, Z, N;

  always #5 clk = ~clk;

  rf_plus_alu dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .WBData(WBData), .MEMData(MEMData),
    .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
    .OprandB(OprandB), .LI(LI), .Buff_OutR(Buff_OutR), .PSW_C(PSW_C),
    .ALUop(ALUop), .Flag(Flag), .Rm(Rm), .Rd(Rd), .OutR(OutR),
    .OutR_EXE(OutR_EXE), .LI_EXE(LI_EXE), .Sum(Sum), .C(C), .Z(Z), .N(N)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference
  logic [15:0] m_rf [8];
  logic [15:0] m_a, m_b, m_d, m_outr;
  logic [7:0]  m_imm;
  logic [15:0] e_rm, e_rd, e_sum, e_li, e_outre;
  logic        e_c, e_z, e_n;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_a = 0; m_b = 0; m_d = 0; m_imm = 0; m_outr = 0;
  endtask

  // Expected outputs from architectural state and the current inputs
  task automatic model_eval();
    int t;
    e_rm = m_rf[Ins[7:5]];
    e_rd = m_rf[RBresource ? Ins[10:8] : Ins[4:2]];
    if (!ALUop) begin
      t   = int'(m_a) + int'(m_b) + ((Flag && PSW_C) ? 1 : 0);
      e_c = (t > 65535);
    end else begin
      t   = int'(m_a) - int'(m_b) - ((Flag && !PSW_C) ? 1 : 0);
      e_c = (t >= 0);
    end
    e_sum   = t[15:0];
    e_z     = (e_sum == 16'h0);
    e_n     = e_sum[15];
    e_li    = LI ? {m_imm, m_d[7:0]} : {8'h00, m_imm};
    e_outre = Buff_OutR ? e_sum : m_outr;
  endtask

  // Clock edge: all reads use pre-edge state, then commit
  task automatic model_clock();
    logic [15:0] na, nb, nd;
    model_eval();
    na = e_rm;
    nb = OprandB ? {11'b0, Ins[4:0]} : e_rd;
    nd = e_rd;
    if (Buff_OutR) m_outr = e_sum;
    m_a = na; m_b = nb; m_d = nd; m_imm = Ins[7:0];
    if (WBRF) m_rf[Ins[10:8]] = WBresource ? MEMData : WBData;
  endtask

  task automatic check_model(input string tag);
    model_eval();
    chk({tag, ".Rm"},       Rm,       e_rm);
    chk({tag, ".Rd"},       Rd,       e_rd);
    chk({tag, ".Sum"},      Sum,      e_sum);
    chk({tag, ".C"},        {15'b0, C}, {15'b0, e_c});
    chk({tag, ".Z"},        {15'b0, Z}, {15'b0, e_z});
    chk({tag, ".N"},        {15'b0, N}, {15'b0, e_n});
    chk({tag, ".LI_EXE"},   LI_EXE,   e_li);
    chk({tag, ".OutR"},     OutR,     m_outr);
    chk({tag, ".OutR_EXE"}, OutR_EXE, e_outre);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------- vector table
  localparam logic [8:0] M_RM = 9'h001, M_RD = 9'h002, M_SUM = 9'h004,
                         M_C = 9'h008, M_Z = 9'h010, M_N = 9'h020,
                         M_LI = 9'h040, M_OUTR = 9'h080, M_OUTRE = 9'h100;

  typedef struct {
    logic [10:0] ins;
    logic [15:0] wbd, memd;
    logic        wbrf, wbres, rbres, oprb, li, buff, pswc, aluop, flag;
    logic [8:0]  mask;
    logic [15:0] rm, rd, sum;
    logic        c, z, n;
    logic [15:0] liv, outr, outre;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic [10:0] ins, input logic [15:0] wbd, input logic [15:0] memd,
    input logic wbrf, input logic wbres, input logic rbres, input logic oprb,
    input logic li, input logic buff, input logic pswc, input logic aluop,
    input logic flag, input logic [8:0] mask,
    input logic [15:0] rm, input logic [15:0] rd, input logic [15:0] sum,
    input logic c, input logic z, input logic n,
    input logic [15:0] liv, input logic [15:0] outr, input logic [15:0] outre);
    vec_t v;
    v.ins = ins; v.wbd = wbd; v.memd = memd; v.wbrf = wbrf; v.wbres = wbres;
    v.rbres = rbres; v.oprb = oprb; v.li = li; v.buff = buff; v.pswc = pswc;
    v.aluop = aluop; v.flag = flag; v.mask = mask; v.rm = rm; v.rd = rd;
    v.sum = sum; v.c = c; v.z = z; v.n = n; v.liv = liv; v.outr = outr;
    v.outre = outre;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    logic [2:0]  a3;
    logic [15:0] val;
    logic [10:0] ins_r1;
    ins_r1 = {3'd0, 3'd1, 3'd1, 2'b00};
    // Fill: same-address read during the write must still show the old 0
    for (int i = 0; i < 8; i++) begin
      a3 = i[2:0]; val = 16'(i + 1);
      add_vec({a3, a3, a3, 2'b00}, val, 16'h0, 1,0,0,0,0,0,0,0,0,
              M_RM | M_RD, 16'h0, 16'h0, 0,0,0,0, 0,0,0);
    end
    // Readback after the write edge
    for (int i = 0; i < 8; i++) begin
      a3 = i[2:0]; val = 16'(i + 1);
      add_vec({a3, a3, a3, 2'b00}, 16'hDEAD, 16'hBEEF, 0,0,0,0,0,0,0,0,0,
              M_RM | M_RD, val, val, 0,0,0,0, 0,0,0);
    end
    // Load r1,r1 into EXE
    add_vec(ins_r1, 0,0, 0,0,0,0,0,0,0,0,0, 9'h0, 0,0,0,0,0,0, 0,0,0);
    // ADD with OutR capture
    add_vec(ins_r1, 0,0, 0,0,0,0,0,1,0,0,0, M_SUM | M_C | M_Z | M_OUTRE,
            0,0,16'd4, 0,0,0, 0,0,16'd4);
    // SUB, OutR holds
    add_vec(ins_r1, 0,0, 0,0,0,0,0,0,0,1,0, M_SUM | M_C | M_Z | M_OUTR | M_OUTRE,
            0,0,16'd0, 1,1,0, 0,16'd4,16'd4);
    // SBC with borrow in
    add_vec(ins_r1, 0,0, 0,0,0,0,0,0,0,1,1, M_SUM | M_C | M_N | M_OUTR,
            0,0,16'hFFFF, 0,0,1, 0,16'd4,0);
    // ADC with carry in; ID loads r1 + imm5 7
    add_vec({3'd0, 3'd1, 5'd7}, 0,0, 0,0,0,1,0,0,1,0,1, M_SUM | M_OUTR,
            0,0,16'd5, 0,0,0, 0,16'd4,0);
    // ADD with immediate; ID loads LHI operands
    add_vec({3'd1, 8'h55}, 0,0, 0,0,1,0,0,0,0,0,0, M_SUM,
            0,0,16'd9, 0,0,0, 0,0,0);
    // LHI result; ID loads LLI operands
    add_vec({3'd1, 8'h44}, 0,0, 0,0,1,0,1,0,0,0,0, M_LI | M_OUTR,
            0,0,0, 0,0,0, 16'h5502,16'd4,0);
    // LLI result; LDR write from memory, read shows old value
    add_vec({3'd1, 8'h00}, 16'h0404, 16'h1100, 1,1,1,0,0,0,0,0,0, M_LI | M_RD,
            0,16'd2,0, 0,0,0, 16'h0044,0,0);
    // LDR readback
    add_vec({3'd1, 8'h00}, 16'h0404, 16'h2222, 0,1,1,0,0,0,0,0,0, M_RD,
            0,16'h1100,0, 0,0,0, 0,0,0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    Ins = v.ins; WBData = v.wbd; MEMData = v.memd; WBRF = v.wbrf;
    WBresource = v.wbres; RBresource = v.rbres; OprandB = v.oprb; LI = v.li;
    Buff_OutR = v.buff; PSW_C = v.pswc; ALUop = v.aluop; Flag = v.flag;
    #1;
    if (v.mask & M_RM)    chk({tag, ".tbl.Rm"},  Rm,  v.rm);
    if (v.mask & M_RD)    chk({tag, ".tbl.Rd"},  Rd,  v.rd);
    if (v.mask & M_SUM)   chk({tag, ".tbl.Sum"}, Sum, v.sum);
    if (v.mask & M_C)     chk({tag, ".tbl.C"},   {15'b0, C}, {15'b0, v.c});
    if (v.mask & M_Z)     chk({tag, ".tbl.Z"},   {15'b0, Z}, {15'b0, v.z});
    if (v.mask & M_N)     chk({tag, ".tbl.N"},   {15'b0, N}, {15'b0, v.n});
    if (v.mask & M_LI)    chk({tag, ".tbl.LI_EXE"}, LI_EXE, v.liv);
    if (v.mask & M_OUTR)  chk({tag, ".tbl.OutR"},   OutR,   v.outr);
    if (v.mask & M_OUTRE) chk({tag, ".tbl.OutR_EXE"}, OutR_EXE, v.outre);
    check_model(tag);
    step();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    Reset = 1'b0; Ins = 0; WBData = 0; MEMData = 0; WBRF = 0; WBresource = 0;
    RBresource = 0; OprandB = 0; LI = 0; Buff_OutR = 0; PSW_C = 0; ALUop = 0;
    Flag = 0;
    model_reset();
    build_table();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.Rm",   Rm,   16'h0);
    chk("reset.Rd",   Rd,   16'h0);
    chk("reset.OutR", OutR, 16'h0);
    chk("reset.Sum",  Sum,  16'h0);
    chk("reset.Z",    {15'b0, Z}, 16'h1);
    Reset = 1'b1;

    foreach (vecs[k]) apply_vec(vecs[k], k);

    // Random traffic against the model
    for (int r = 0; r < 400; r++) begin
      Ins        = 11'($urandom);
      WBData     = 16'($urandom);
      MEMData    = 16'($urandom);
      WBRF       = 1'($urandom);
      WBresource = 1'($urandom);
      RBresource = 1'($urandom);
      OprandB    = 1'($urandom);
      LI         = 1'($urandom);
      Buff_OutR  = 1'($urandom);
      PSW_C      = 1'($urandom);
      ALUop      = 1'($urandom);
      Flag       = 1'($urandom);
      #1;
      check_model($sformatf("rnd%0d", r));
      step();
    end

    // Asynchronous reset mid-cycle, no clock edge needed
    Buff_OutR = 1'b0; WBRF = 1'b0;
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("areset.OutR", OutR, 16'h0);
    check_model("areset");
    #1;
    Reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_plus_alu.md
Name: rf_plus_alu

Overview:
- Register-file plus ALU datapath slice for the multicycle 16-bit RISC core.
- ID stage: 8x16 register file with two combinational read ports and one synchronous write port.
- ID/EXE pipeline register.
- EXE stage: 16-bit add/sub ALU with carry/flags, load-immediate formatter and a buffered result register (OutR).
- All control signals come from the external controller.

Parameters:
- DW, 16, datapath width.
- AW, 3, register address width (2^AW = 8 registers).

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous active-low reset.
- Ins  in  11  instruction field: [10:8]=Rd addr, [7:5]=Rm addr, [4:2]=Rn addr, [7:0]=imm8.
- WBData  in  16  write-back data from the core.
- MEMData  in  16  load data from memory.
- WBRF  in  1  register-file write enable.
- WBresource  in  1  write-data select: 0 = WBData, 1 = MEMData.
- RBresource  in  1  port-B read address select: 0 = Ins[4:2], 1 = Ins[10:8].
- OprandB  in  1  ALU operand-B select: 0 = port-B data, 1 = zero-extended Ins[4:0].
- LI  in  1  load-immediate type: 1 = LHI, 0 = LLI.
- Buff_OutR  in  1  OutR load enable.
- PSW_C  in  1  carry flag from PSW.
- ALUop  in  1  0 = add, 1 = subtract.
- Flag  in  1  1 = include PSW_C (ADC/SBC).
- Rm  out  16  RF[Ins[7:5]], combinational.
- Rd  out  16  port-B data RF[RBresource ? Ins[10:8] : Ins[4:2]], combinational.
- OutR  out  16  buffered result register.
- OutR_EXE  out  16  Buff_OutR ? Sum : OutR.
- LI_EXE  out  16  load-immediate result.
- Sum  out  16  ALU result.
- C  out  1  ALU carry out.
- Z  out  1  Sum == 0.
- N  out  1  Sum[15].

Behaviour:
- Reset low (asynchronous): all 8 registers, ID/EXE registers and OutR clear to 0. Sum, LI_EXE and flags then follow combinationally from the zeroed registers.
- RF write: on posedge clk when WBRF=1, RF[Ins[10:8]] <= (WBresource ? MEMData : WBData). No write when WBRF=0.
- RF read: both ports combinational, no internal write-to-read bypass. A value written in cycle n is readable after that edge.
- ID/EXE register, loaded every posedge with no enable:
  - A_EXE <= Rm.
  - B_EXE <= OprandB ? {11'b0, Ins[4:0]} : Rd.
  - D_EXE <= Rd.
  - IMM_EXE <= Ins[7:0].
- Stage timing:
  - RBresource, OprandB, WBRF and WBresource act in the ID cycle.
  - ALUop, Flag, PSW_C, LI and Buff_OutR act combinationally on the EXE registers in the following cycle.
- ALU, with cin = Flag ? PSW_C : 1 for subtract:
  - add: {C,Sum} = A_EXE + B_EXE + (Flag & PSW_C).
  - sub: {C,Sum} = A_EXE + ~B_EXE + cin. C=1 means no borrow.
  - Z = (Sum == 0); N = Sum[15].
  - Unsigned 17-bit arithmetic; wrap-around discards overflow beyond bit 16.
- LI_EXE:
  - LI=1 (LHI): {IMM_EXE, D_EXE[7:0]}.
  - LI=0 (LLI): {8'h00, IMM_EXE}.
- OutR: on posedge, if Buff_OutR=1 then OutR <= Sum; otherwise it holds.
- X on a control input whose path is unused must not corrupt state: with WBRF=0 the RF is unchanged regardless of the other inputs.
- Simultaneous RF write and read of the same address in one cycle: the read returns the old value.

Decomposition:
- Shared package rf_alu_pkg holds:
  - DW and AW.
  - ALUop encodings ALU_ADD=0, ALU_SUB=1.
  - Instruction field slice constants.
- One sub-module, rf8x16: register file with async reset, 1 write port and 2 read ports.
- ALU, ID/EXE register and LI formatter stay inline.

Test Plan:
- Reset: hold Reset=0 for 3 cycles. Then Rm=Rd=0, OutR=0, Sum=0, Z=1.
- Fill: for i=0..7, WBRF=1, WBresource=0, WBData=i+1, Ins addr fields=i. One cycle later Rm=Rd=i+1.
- ALU cases after fill, Rm=Rn=r1 (value 2):
  - ADD -> Sum=4, C=0, Z=0.
  - SUB with Flag=0 -> Sum=0, Z=1, C=1.
  - SBC with Flag=1, PSW_C=0 -> Sum=0xFFFF, N=1, C=0.
  - ADC with Flag=1, PSW_C=1 -> Sum=5.
- LHI/LLI, RF[1]=2:
  - Ins={3'd1, 8'h55}, RBresource=1, LI=1 -> next cycle LI_EXE=0x5502.
  - Ins={3'd1, 8'h44}, LI=0 -> LI_EXE=0x0044.
- LDR: Ins[10:8]=1, WBRF=1, WBresource=1, MEMData=0x1100 -> after the edge, Rd (RBresource=1) = 0x1100. WBData=0x0404 is ignored.
- OutR: Buff_OutR=1 with Sum=4 -> OutR_EXE=4 that cycle and OutR=4 after the edge. Then Buff_OutR=0 -> OutR holds 4 while Sum changes.
